axi_ddr_resp: RTL and testbench

- AXI slave/responder that terminates the frame-buffer AXI master port (aw/w/ar/r channels) on an on-chip memory, in the ddr_clk domain.
- Replaces the DDR controller for small-frame bring-up and for closed-loop simulation of the write/read buffer path.
- Uses the controller-side signalling conventions: the slave drives axi_wlast, and there is no B channel.
- Serves one burst at a time and arbitrates write and read bursts round-robin.

---
 rtl/axi_ddr_resp.sv | 182 ++++++++++++++++++
 tb/tb_axi_ddr_resp.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ddr_resp.sv
// AXI responder backed by on-chip memory: serves one write or read burst
// at a time, round-robin between write and read on simultaneous requests.
// The slave drives axi_wlast; there is no B channel.
module axi_ddr_resp #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_DQ_WIDTH    = 32,
    parameter int MEM_DEPTH_WIDTH = 10,
    parameter int ADDR_LSB        = 3
) (
    input  logic                        ddr_clk,
    input  logic                        ddr_rstn,
    input  logic [CTRL_ADDR_WIDTH-1:0]  axi_awaddr,
    input  logic [3:0]                  axi_awid,
    input  logic [3:0]                  axi_awlen,
    input  logic [2:0]                  axi_awsize,
    input  logic [1:0]                  axi_awburst,
    input  logic                        axi_awvalid,
    output logic                        axi_awready,
    input  logic [8*MEM_DQ_WIDTH-1:0]   axi_wdata,
    input  logic [MEM_DQ_WIDTH-1:0]     axi_wstrb,
    input  logic                        axi_wvalid,
    output logic                        axi_wready,
    output logic                        axi_wlast,
    input  logic [CTRL_ADDR_WIDTH-1:0]  axi_araddr,
    input  logic [3:0]                  axi_arid,
    input  logic [3:0]                  axi_arlen,
    input  logic [2:0]                  axi_arsize,
    input  logic [1:0]                  axi_arburst,
    input  logic                        axi_arvalid,
    output logic                        axi_arready,
    output logic [8*MEM_DQ_WIDTH-1:0]   axi_rdata,
    output logic                        axi_rvalid,
    output logic                        axi_rlast,
    output logic [3:0]                  axi_rid,
    input  logic                        axi_rready,
    output logic                        busy
);
    localparam int DW = 8*MEM_DQ_WIDTH;
    localparam int IW = MEM_DEPTH_WIDTH;

    typedef enum logic [1:0] {IDLE, WR, RD, RD_DRAIN} state_t;

    state_t          state;
    logic            last_rd;      // last grant went to the read side
    logic [3:0]      len;
    logic [3:0]      beat_cnt;
    logic [3:0]      sent_cnt;
    logic [4:0]      fetch_cnt;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   fetch_idx;
    logic [IW-1:0]   aw_idx;
    logic [IW-1:0]   ar_idx;
    logic [IW-1:0]   rd_idx;
    logic            pend;         // RAM read in flight, data lands in rd_q
    logic [DW-1:0]   rd_q;
    logic [DW-1:0]   skid [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      occ;
    logic            grant_wr;
    logic            grant_rd;
    logic            idle;
    logic            wbeat;
    logic            pop;
    logic            fetch_more;
    logic            rd_en;
    logic [2:0]      fill;
    logic [2:0]      limit;
    logic            unused_ok;

    logic [DW-1:0]   mem [(1<<IW)];

    // Only the word-index bits of the address matter; upper bits alias.
    assign aw_idx = axi_awaddr[ADDR_LSB+IW-1:ADDR_LSB];
    assign ar_idx = axi_araddr[ADDR_LSB+IW-1:ADDR_LSB];
    assign unused_ok = ^{axi_awid, axi_awsize, axi_awburst, axi_arsize,
                         axi_arburst, axi_awaddr, axi_araddr};

    // Tie goes to the side that did not win last time.
    assign grant_wr    = axi_awvalid & (~axi_arvalid | last_rd);
    assign grant_rd    = axi_arvalid & (~axi_awvalid | ~last_rd);
    // Reset gating keeps the combinational readies low while in reset.
    assign idle        = (state == IDLE) & ddr_rstn;
    assign axi_awready = idle & grant_wr;
    assign axi_arready = idle & grant_rd;

    assign axi_wready  = (state == WR);
    assign axi_wlast   = axi_wready & (beat_cnt == len);
    assign wbeat       = axi_wvalid & axi_wready;

    assign axi_rvalid  = (occ != 2'd0);
    assign axi_rdata   = skid[rd_ptr];
    assign axi_rlast   = axi_rvalid & (sent_cnt == len);
    assign pop         = axi_rvalid & axi_rready;
    assign busy        = (state != IDLE);

    // A slot freed by this cycle's pop counts, so beats stream back to back.
    assign fill       = {1'b0, occ} + {2'b00, pend};
    assign limit      = 3'd2 + {2'b00, pop};
    assign fetch_more = (state == RD) & (fetch_cnt <= {1'b0, len}) & (fill < limit);
    // First fetch goes out in the accept cycle to meet the 2-cycle rvalid latency.
    assign rd_en      = axi_arready | fetch_more;
    assign rd_idx     = axi_arready ? ar_idx : fetch_idx;

    // Byte-enabled write port and 1-cycle synchronous read port; not reset.
    always_ff @(posedge ddr_clk) begin
        if (wbeat) begin
            for (int i = 0; i < MEM_DQ_WIDTH; i++) begin
                if (axi_wstrb[i]) mem[wr_idx][i*8 +: 8] <= axi_wdata[i*8 +: 8];
            end
        end
        if (rd_en) rd_q <= mem[rd_idx];
    end

    // Burst FSM, counters and the 2-entry read skid buffer.
    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            state     <= IDLE;
            last_rd   <= 1'b1;
            len       <= '0;
            beat_cnt  <= '0;
            sent_cnt  <= '0;
            fetch_cnt <= '0;
            wr_idx    <= '0;
            fetch_idx <= '0;
            axi_rid   <= '0;
            pend      <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= '0;
            skid[0]   <= '0;
            skid[1]   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (axi_awready) begin
                        state    <= WR;
                        last_rd  <= 1'b0;
                        len      <= axi_awlen;
                        wr_idx   <= aw_idx;
                        beat_cnt <= '0;
                    end else if (axi_arready) begin
                        state     <= RD;
                        last_rd   <= 1'b1;
                        len       <= axi_arlen;
                        axi_rid   <= axi_arid;
                        fetch_idx <= ar_idx + 1'b1;
                        fetch_cnt <= 5'd1;
                        sent_cnt  <= '0;
                    end
                end
                WR: begin
                    if (wbeat) begin
                        wr_idx   <= wr_idx + 1'b1;
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_cnt == len) state <= IDLE;
                    end
                end
                RD: begin
                    if (fetch_more) begin
                        fetch_idx <= fetch_idx + 1'b1;
                        fetch_cnt <= fetch_cnt + 5'd1;
                    end
                    if (fetch_cnt > {1'b0, len}) state <= RD_DRAIN;
                end
                default: ;
            endcase

            pend <= rd_en;
            if (pend) begin
                skid[wr_ptr] <= rd_q;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                sent_cnt <= sent_cnt + 4'd1;
                if (axi_rlast) state <= IDLE;
            end
            occ <= occ + {1'b0, pend} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_axi_ddr_resp.sv
// Directed bench for axi_ddr_resp: a scoreboard queue holds expected read
// beats, a negedge monitor pops and compares on each rvalid&rready.
module tb_axi_ddr_resp;
    logic         ddr_clk = 1'b0;
    logic         ddr_rstn;
    logic [27:0]  awaddr, araddr;
    logic [3:0]   awid, awlen, arid, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic         awvalid, awready, wvalid, wready, wlast;
    logic [255:0] wdata, rdata;
    logic [31:0]  wstrb;
    logic         arvalid, arready, rvalid, rlast, rready, busy;
    logic [3:0]   rid;

    typedef struct { logic [255:0] d; logic last; logic [3:0] id; } beat_t;
    beat_t sb[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int t0;

    axi_ddr_resp dut (
        .ddr_clk(ddr_clk), .ddr_rstn(ddr_rstn),
        .axi_awaddr(awaddr), .axi_awid(awid), .axi_awlen(awlen),
        .axi_awsize(awsize), .axi_awburst(awburst), .axi_awvalid(awvalid),
        .axi_awready(awready), .axi_wdata(wdata), .axi_wstrb(wstrb),
        .axi_wvalid(wvalid), .axi_wready(wready), .axi_wlast(wlast),
        .axi_araddr(araddr), .axi_arid(arid), .axi_arlen(arlen),
        .axi_arsize(arsize), .axi_arburst(arburst), .axi_arvalid(arvalid),
        .axi_arready(arready), .axi_rdata(rdata), .axi_rvalid(rvalid),
        .axi_rlast(rlast), .axi_rid(rid), .axi_rready(rready), .busy(busy)
    );

    always #5 ddr_clk = ~ddr_clk;
    always @(posedge ddr_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        checks++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    task automatic push(input logic [255:0] d, input logic last, input logic [3:0] id);
        beat_t b;
        b.d = d; b.last = last; b.id = id;
        sb.push_back(b);
    endtask

    // Monitor: every read handshake must match the head of the scoreboard.
    always @(negedge ddr_clk) begin
        if (ddr_rstn && rvalid && rready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_beat: rdata=%0h with empty scoreboard", rdata);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("rbeat{data,last,id}", {rdata, rlast, rid}, {e.d, e.last, e.id});
            end
        end
    end

    task automatic check_zero(input string nm);
        chk(nm, {awready, arready, wready, wlast, rvalid, rlast, busy, rid, rdata}, '0);
    endtask

    task automatic aw_req(input logic [27:0] a, input logic [3:0] l);
        int k = 0;
        awaddr = a; awlen = l; awvalid = 1'b1;
        #1;
        while (!awready && k < 100) begin @(negedge ddr_clk); k++; end
        if (!awready) tmo("awready");
        @(posedge ddr_clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_data(input int n, input logic [255:0] base, input logic [31:0] strb);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            wdata = base + 256'(i); wstrb = strb; wvalid = 1'b1;
            while (!wready && k < 100) begin @(negedge ddr_clk); k++; end
            if (!wready) begin tmo("wready"); wvalid = 1'b0; return; end
            chk("wlast", wlast, (i == n - 1));
            @(posedge ddr_clk); #1;
        end
        wvalid = 1'b0;
        @(negedge ddr_clk);
        chk("wready_drop_after_last", wready, 1'b0);
    endtask

    task automatic ar_req(input logic [27:0] a, input logic [3:0] l, input logic [3:0] id, output int t);
        int k = 0;
        araddr = a; arlen = l; arid = id; arvalid = 1'b1;
        #1;
        while (!arready && k < 100) begin @(negedge ddr_clk); k++; end
        if (!arready) tmo("arready");
        t = cyc;
        @(posedge ddr_clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic r_drain(input bit bp, input int ta);
        int k = 0;
        bit first = 1'b1;
        logic [3:0] pat = 4'b1001;
        while (sb.size() != 0 && k < 300) begin
            @(negedge ddr_clk);
            if (first && rvalid) begin
                first = 1'b0;
                chk("first_rvalid_latency", 32'(cyc - ta), 32'd2);
            end
            @(posedge ddr_clk); #1;
            k++;
            rready = bp ? pat[k % 4] : 1'b1;
        end
        if (sb.size() != 0) tmo("read_drain");
        rready = 1'b1;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge ddr_clk);
        while (busy && k < 100) begin @(negedge ddr_clk); k++; end
        if (busy) tmo("busy_clear");
    endtask

    initial begin
        ddr_rstn = 1'b0;
        awaddr = '0; awid = 4'h1; awlen = '0; awsize = 3'd5; awburst = 2'b01; awvalid = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arsize = 3'd5; arburst = 2'b01; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; rready = 1'b1;
        repeat (3) @(posedge ddr_clk);
        @(negedge ddr_clk);
        check_zero("reset_outputs");
        @(posedge ddr_clk); #1;
        ddr_rstn = 1'b1;

        // Tie from reset: write first, then the waiting read.
        araddr = 28'h10; arlen = 4'd0; arid = 4'h7; arvalid = 1'b1;
        awaddr = 28'h10; awlen = 4'd0; awvalid = 1'b1;
        #1;
        chk("tie1_grant{aw,ar}", {awready, arready}, 2'b10);
        aw_req(28'h10, 4'd0);
        w_data(1, 256'hD0, '1);
        chk("tie1_read_follows", arready, 1'b1);
        push(256'hD0, 1'b1, 4'h7);
        ar_req(28'h10, 4'd0, 4'h7, t0);
        r_drain(1'b0, t0);
        wait_idle();

        // Second tie: last grant was read, so write again.
        araddr = 28'h18; arlen = 4'd0; arid = 4'h8; arvalid = 1'b1;
        awaddr = 28'h18; awlen = 4'd0; awvalid = 1'b1;
        #1;
        chk("tie2_grant{aw,ar}", {awready, arready}, 2'b10);
        aw_req(28'h18, 4'd0);
        w_data(1, 256'hD1, '1);
        chk("tie2_read_follows", arready, 1'b1);
        push(256'hD1, 1'b1, 4'h8);
        ar_req(28'h18, 4'd0, 4'h8, t0);
        r_drain(1'b0, t0);
        wait_idle();

        // Write 4 beats at 0x40 then read them back.
        aw_req(28'h40, 4'd3);
        w_data(4, 256'hA0, '1);
        for (int i = 0; i < 4; i++) push(256'hA0 + 256'(i), (i == 3), 4'h5);
        ar_req(28'h40, 4'd3, 4'h5, t0);
        r_drain(1'b0, t0);
        wait_idle();

        // Partial strobe over an all-ones word 5.
        aw_req(28'h28, 4'd0);
        w_data(1, {256{1'b1}}, '1);
        aw_req(28'h28, 4'd0);
        w_data(1, 256'h0, 32'h0000_000F);
        push({{224{1'b1}}, 32'h0}, 1'b1, 4'h2);
        ar_req(28'h28, 4'd0, 4'h2, t0);
        r_drain(1'b0, t0);
        wait_idle();

        // Wrap: 4 beats from word 1022 land in 1022, 1023, 0, 1.
        aw_req(28'h1FF0, 4'd3);
        w_data(4, 256'hB0, '1);
        push(256'hB2, 1'b0, 4'h3);
        push(256'hB3, 1'b1, 4'h3);
        ar_req(28'h0, 4'd1, 4'h3, t0);
        r_drain(1'b0, t0);
        wait_idle();
        push(256'hB0, 1'b0, 4'h4);
        push(256'hB1, 1'b1, 4'h4);
        ar_req(28'h1FF0, 4'd1, 4'h4, t0);
        r_drain(1'b0, t0);
        wait_idle();
        // Bit 13 is above the word index, so this aliases word 0.
        push(256'hB2, 1'b1, 4'h6);
        ar_req(28'h0002000, 4'd0, 4'h6, t0);
        r_drain(1'b0, t0);
        wait_idle();

        // 16-beat read under 1-0-0-1 rready backpressure.
        aw_req(28'h320, 4'd15);
        w_data(16, 256'hC0, '1);
        for (int i = 0; i < 16; i++) push(256'hC0 + 256'(i), (i == 15), 4'h9);
        ar_req(28'h320, 4'd15, 4'h9, t0);
        r_drain(1'b1, t0);
        wait_idle();

        // Reset during beat 2 of an 8-beat read.
        for (int i = 0; i < 8; i++) push(256'hC0 + 256'(i), (i == 7), 4'hA);
        ar_req(28'h320, 4'd7, 4'hA, t0);
        begin
            int k = 0;
            while (sb.size() > 6 && k < 50) begin @(posedge ddr_clk); #1; k++; end
            if (sb.size() > 6) tmo("beat2_of_8");
        end
        ddr_rstn = 1'b0;
        #1;
        check_zero("midburst_reset_outputs");
        sb.delete();
        @(posedge ddr_clk); #1;
        ddr_rstn = 1'b1;
        awaddr = 28'h30; awlen = 4'd0; awvalid = 1'b1;
        #1;
        chk("post_reset_awready", awready, 1'b1);
        aw_req(28'h30, 4'd0);
        w_data(1, 256'hE0, '1);
        push(256'hE0, 1'b1, 4'hB);
        ar_req(28'h30, 4'd0, 4'hB, t0);
        r_drain(1'b0, t0);
        wait_idle();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
